// File: rtl/ulpb_pkg.sv
// Shared ULPB constants: default receive-path widths, buffer depth and
// the encodings of the receive handshake states.
package ulpb_pkg;

    localparam int ULPB_ADDR_WIDTH = 8;
    localparam int ULPB_DATA_WIDTH = 32;
    localparam int ULPB_RX_DEPTH   = 8;

    localparam logic [0:0] RX_ST_IDLE  = 1'b0;
    localparam logic [0:0] RX_ST_ACKED = 1'b1;

    // Pointer/count width: one extra bit beyond the index so full and empty differ.
    function automatic int ulpb_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ulpb_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; the head word is read straight
// from registered storage so the output depends only on flop state.
module ulpb_sync_fifo
    import ulpb_pkg::*;
#(
    parameter int WIDTH = ULPB_ADDR_WIDTH + ULPB_DATA_WIDTH + 1,
    parameter int DEPTH = ULPB_RX_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic [ulpb_ptr_w(DEPTH)-1:0] count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = ulpb_ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_wr);
        rd_ptr_d = rd_ptr_q + PW'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/ulpb_rx_buffer.sv
// Receive buffer between a node's 4-phase receive port and the layer above:
// accepts one word per REQ/ACK cycle into a FIFO and tracks whole messages held.
module ulpb_rx_buffer
    import ulpb_pkg::*;
#(
    parameter int ADDR_WIDTH = ULPB_ADDR_WIDTH,
    parameter int DATA_WIDTH = ULPB_DATA_WIDTH,
    parameter int DEPTH      = ULPB_RX_DEPTH
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [ADDR_WIDTH-1:0]        RX_ADDR,
    input  logic [DATA_WIDTH-1:0]        RX_DATA,
    input  logic                         RX_PEND,
    input  logic                         RX_REQ,
    output logic                         RX_ACK,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [ADDR_WIDTH-1:0]        OUT_ADDR,
    output logic [DATA_WIDTH-1:0]        OUT_DATA,
    output logic                         OUT_LAST,
    output logic [ulpb_ptr_w(DEPTH)-1:0] COUNT,
    output logic [ulpb_ptr_w(DEPTH)-1:0] MSG_CNT,
    output logic                         FULL,
    output logic                         EMPTY,
    output logic                         STALL
);

    localparam int CW = ulpb_ptr_w(DEPTH);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH + 1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] msg_cnt_q, msg_cnt_d;
    logic          wr_en, pop;
    logic [EW-1:0] wr_entry, rd_entry;
    logic          fifo_full, fifo_empty;

    // Acceptance uses the registered FULL, so a pop in the same cycle cannot
    // open space for a write until the following edge.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        if (state_q == RX_ST_IDLE) begin
            if (RX_REQ && !fifo_full) begin
                wr_en   = 1'b1;
                state_d = RX_ST_ACKED;
            end
        end else if (!RX_REQ) begin
            state_d = RX_ST_IDLE;
        end
    end

    assign pop = OUT_READY && !fifo_empty;

    always_comb begin
        msg_cnt_d = msg_cnt_q + CW'(wr_en && !RX_PEND) - CW'(pop && rd_entry[0]);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= RX_ST_IDLE;
            msg_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            msg_cnt_q <= msg_cnt_d;
        end
    end

    assign wr_entry = {RX_ADDR, RX_DATA, ~RX_PEND};

    ulpb_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESET),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .count   (COUNT),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign RX_ACK    = (state_q == RX_ST_ACKED);
    assign OUT_VALID = !fifo_empty;
    assign OUT_ADDR  = rd_entry[EW-1 -: ADDR_WIDTH];
    assign OUT_DATA  = rd_entry[DATA_WIDTH:1];
    assign OUT_LAST  = rd_entry[0];
    assign MSG_CNT   = msg_cnt_q;
    assign FULL      = fifo_full;
    assign EMPTY     = fifo_empty;
    assign STALL     = RX_REQ && !RX_ACK && fifo_full;

endmodule

// File: tb/tb_ulpb_rx_buffer.sv
// Directed bench for ulpb_rx_buffer at default parameters (8-bit address,
// 32-bit data, 8 entries); inputs change and outputs are sampled on negedge.
module tb_ulpb_rx_buffer;

    logic        CLK;
    logic        RESET;
    logic [7:0]  RX_ADDR;
    logic [31:0] RX_DATA;
    logic        RX_PEND;
    logic        RX_REQ;
    logic        RX_ACK;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [7:0]  OUT_ADDR;
    logic [31:0] OUT_DATA;
    logic        OUT_LAST;
    logic [3:0]  COUNT;
    logic [3:0]  MSG_CNT;
    logic        FULL;
    logic        EMPTY;
    logic        STALL;

    int n_checks = 0;
    int n_errors = 0;

    ulpb_rx_buffer dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .RX_ADDR   (RX_ADDR),
        .RX_DATA   (RX_DATA),
        .RX_PEND   (RX_PEND),
        .RX_REQ    (RX_REQ),
        .RX_ACK    (RX_ACK),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_ADDR  (OUT_ADDR),
        .OUT_DATA  (OUT_DATA),
        .OUT_LAST  (OUT_LAST),
        .COUNT     (COUNT),
        .MSG_CNT   (MSG_CNT),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .STALL     (STALL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full 4-phase cycle with bounded waits on both ACK edges.
    task automatic send_word(input logic [7:0] a, input logic [31:0] d, input logic p);
        RX_ADDR = a;
        RX_DATA = d;
        RX_PEND = p;
        RX_REQ  = 1'b1;
        for (int i = 0; i < 20 && !RX_ACK; i++) tick();
        chk("send_ack_rise", RX_ACK, 1);
        RX_REQ = 1'b0;
        for (int i = 0; i < 20 && RX_ACK; i++) tick();
        chk("send_ack_fall", RX_ACK, 0);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] a, input logic [31:0] d,
                             input logic last);
        chk({tag, "_valid"}, OUT_VALID, 1);
        chk({tag, "_addr"}, OUT_ADDR, a);
        chk({tag, "_data"}, OUT_DATA, d);
        chk({tag, "_last"}, OUT_LAST, last);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
    endtask

    function automatic logic [7:0] wa(input int i);
        return 8'h40 + 8'(i);
    endfunction

    function automatic logic [31:0] wd(input int i);
        return 32'hC0DE_0000 + 32'(i * 3);
    endfunction

    function automatic logic wl(input int i);
        return (i % 4) == 3;
    endfunction

    initial begin
        int exp_msgs;
        RESET     = 1'b0;
        RX_ADDR   = '0;
        RX_DATA   = '0;
        RX_PEND   = 1'b0;
        RX_REQ    = 1'b0;
        OUT_READY = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_ack", RX_ACK, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_msg", MSG_CNT, 0);
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_stall", STALL, 0);
        RESET = 1'b1;
        tick();

        // Single word, ACK one cycle after REQ
        RX_ADDR = 8'hcd;
        RX_DATA = 32'h1234_5678;
        RX_PEND = 1'b0;
        RX_REQ  = 1'b1;
        chk("single_ack_pre", RX_ACK, 0);
        tick();
        chk("single_ack", RX_ACK, 1);
        chk("single_valid", OUT_VALID, 1);
        chk("single_last", OUT_LAST, 1);
        chk("single_count", COUNT, 1);
        chk("single_msg", MSG_CNT, 1);
        chk("single_addr", OUT_ADDR, 8'hcd);
        chk("single_data", OUT_DATA, 32'h1234_5678);
        RX_REQ = 1'b0;
        tick();
        chk("single_ack_fall", RX_ACK, 0);
        chk("single_count_hold", COUNT, 1);
        pop_check("single_pop", 8'hcd, 32'h1234_5678, 1);
        chk("single_empty", EMPTY, 1);
        chk("single_msg0", MSG_CNT, 0);

        // OUT_READY while empty does nothing
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        chk("idle_ready_count", COUNT, 0);
        chk("idle_ready_empty", EMPTY, 1);

        // Eight-word message fills the buffer
        for (int i = 0; i < 8; i++) send_word(8'h10 + 8'(i), 32'hA000_0000 + 32'(i), i < 7);
        chk("stream_full", FULL, 1);
        chk("stream_count", COUNT, 8);
        chk("stream_msg", MSG_CNT, 1);
        chk("stream_empty", EMPTY, 0);

        // Ninth word stalls until one pop frees space
        RX_ADDR = 8'h55;
        RX_DATA = 32'hDEAD_BEEF;
        RX_PEND = 1'b0;
        RX_REQ  = 1'b1;
        tick();
        tick();
        chk("ovf_ack", RX_ACK, 0);
        chk("ovf_stall", STALL, 1);
        chk("ovf_count", COUNT, 8);
        chk("ovf_head_addr", OUT_ADDR, 8'h10);
        chk("ovf_head_data", OUT_DATA, 32'hA000_0000);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        chk("ovf_pop_ack", RX_ACK, 0);
        chk("ovf_pop_count", COUNT, 7);
        chk("ovf_pop_stall", STALL, 0);
        tick();
        chk("ovf_accept_ack", RX_ACK, 1);
        chk("ovf_accept_stall", STALL, 0);
        chk("ovf_accept_count", COUNT, 8);
        chk("ovf_accept_msg", MSG_CNT, 2);
        RX_REQ = 1'b0;
        tick();
        chk("ovf_ack_fall", RX_ACK, 0);
        for (int i = 1; i < 8; i++)
            pop_check("stream_pop", 8'h10 + 8'(i), 32'hA000_0000 + 32'(i), i == 7);
        chk("stream_msg_after", MSG_CNT, 1);
        pop_check("ovf_word_pop", 8'h55, 32'hDEAD_BEEF, 1);
        chk("drain_empty", EMPTY, 1);
        chk("drain_msg", MSG_CNT, 0);

        // Simultaneous write and pop at COUNT=3 across pointer wrap
        for (int i = 0; i < 3; i++) send_word(wa(i), wd(i), !wl(i));
        chk("wrap_fill_count", COUNT, 3);
        for (int k = 0; k < 20; k++) begin
            chk("wrap_head_addr", OUT_ADDR, wa(k));
            chk("wrap_head_data", OUT_DATA, wd(k));
            chk("wrap_head_last", OUT_LAST, wl(k));
            RX_ADDR   = wa(k + 3);
            RX_DATA   = wd(k + 3);
            RX_PEND   = !wl(k + 3);
            RX_REQ    = 1'b1;
            OUT_READY = 1'b1;
            tick();
            OUT_READY = 1'b0;
            exp_msgs = int'(wl(k + 1)) + int'(wl(k + 2)) + int'(wl(k + 3));
            chk("wrap_count", COUNT, 3);
            chk("wrap_ack", RX_ACK, 1);
            chk("wrap_msg", MSG_CNT, 64'(exp_msgs));
            RX_REQ = 1'b0;
            tick();
            chk("wrap_ack_fall", RX_ACK, 0);
        end
        for (int k = 20; k < 23; k++) pop_check("wrap_drain", wa(k), wd(k), wl(k));
        chk("wrap_empty", EMPTY, 1);

        // REQ held high for ten cycles writes exactly once
        RX_ADDR = 8'h77;
        RX_DATA = 32'h0000_0001;
        RX_PEND = 1'b0;
        RX_REQ  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_ack", RX_ACK, 1);
            chk("hold_count", COUNT, 1);
        end
        RX_REQ = 1'b0;
        tick();
        chk("hold_ack_fall", RX_ACK, 0);
        chk("hold_count_after", COUNT, 1);
        pop_check("hold_pop", 8'h77, 32'h0000_0001, 1);

        // Reset while ACKED with five entries held
        for (int i = 0; i < 4; i++) send_word(8'h90 + 8'(i), 32'h5000_0000 + 32'(i), 1'b1);
        RX_ADDR = 8'h94;
        RX_DATA = 32'h5000_0004;
        RX_PEND = 1'b1;
        RX_REQ  = 1'b1;
        tick();
        chk("mid_ack", RX_ACK, 1);
        chk("mid_count", COUNT, 5);
        RESET = 1'b0;
        tick();
        chk("mid_rst_ack", RX_ACK, 0);
        chk("mid_rst_count", COUNT, 0);
        chk("mid_rst_empty", EMPTY, 1);
        chk("mid_rst_valid", OUT_VALID, 0);
        chk("mid_rst_msg", MSG_CNT, 0);
        RESET  = 1'b1;
        RX_REQ = 1'b0;
        tick();

        // Normal operation resumes after reset
        send_word(8'h3c, 32'hCAFE_F00D, 1'b0);
        chk("post_rst_count", COUNT, 1);
        chk("post_rst_msg", MSG_CNT, 1);
        pop_check("post_rst_pop", 8'h3c, 32'hCAFE_F00D, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ulpb_rx_buffer.md
ULPB_RX_BUFFER -- requirements
Module: ulpb_rx_buffer

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 8, address width; DATA_WIDTH, default 32, data word width; DEPTH, default 8, FIFO entries (power of two, ≥2).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-low reset.
REQ-004 RX_ADDR  input  ADDR_WIDTH  destination address from node receive port.
REQ-005 RX_DATA  input  DATA_WIDTH  received word.
REQ-006 RX_PEND  input  1  high = more words follow in this message; low = last word.
REQ-007 RX_REQ  input  1  node offers a word (4-phase request).
REQ-008 RX_ACK  output  1  word accepted (4-phase acknowledge).
REQ-009 OUT_VALID  output  1  head entry available to layer.
REQ-010 OUT_READY  input  1  layer consumes head entry when OUT_VALID high.
REQ-011 OUT_ADDR / OUT_DATA / OUT_LAST  output  ADDR_WIDTH / DATA_WIDTH / 1  head entry fields; OUT_LAST = stored ~RX_PEND.
REQ-012 COUNT  output  log2(DEPTH)+1  entries held.
REQ-013 MSG_CNT  output  log2(DEPTH)+1  complete messages held (entries with OUT_LAST=1).
REQ-014 FULL, EMPTY  output  1  COUNT==DEPTH, COUNT==0.
REQ-015 STALL  output  1  high while RX_REQ high, RX_ACK low and FULL high.

Function
REQ-016 Handshake FSM SHALL have states IDLE and ACKED.
REQ-017 In IDLE, sampling RX_REQ=1 and FULL=0 SHALL write {RX_ADDR, RX_DATA, ~RX_PEND} at the write pointer, set RX_ACK=1 next cycle and enter ACKED.
REQ-018 In IDLE with RX_REQ=1 and FULL=1, RX_ACK SHALL stay 0 and no write occurs; acceptance proceeds on the first cycle FULL=0 (node-side timeout/fail is the node's responsibility).
REQ-019 In ACKED, sampling RX_REQ=0 SHALL clear RX_ACK next cycle and return to IDLE; RX_REQ held high keeps ACKED with no further write.
REQ-020 Exactly one write per 4-phase cycle; minimum cycle REQ↑→ACK↑→REQ↓→ACK↓ is 2 CLK cycles of this block.
REQ-021 Write-to-OUT_VALID latency SHALL be 1 cycle (registered FIFO state, no combinational bypass from RX_* to OUT_*).
REQ-022 Pop SHALL occur when OUT_VALID & OUT_READY; OUT_* SHALL show the next entry the following cycle.
REQ-023 FULL used for acceptance SHALL be the registered value; a same-cycle pop does not enable a write into a full buffer.
REQ-024 Simultaneous write and pop SHALL leave COUNT unchanged; MSG_CNT likewise nets +1 (written LAST) and −1 (popped LAST).
REQ-025 Pointers SHALL be log2(DEPTH)+1 bits, wrapping modulo 2·DEPTH; FULL/EMPTY derived from pointer MSB/LSB comparison and SHALL agree with COUNT.
REQ-026 OUT_ADDR/OUT_DATA/OUT_LAST are don't-care when OUT_VALID=0; OUT_READY with OUT_VALID=0 SHALL have no effect.

Reset
REQ-027 RESET=0 at a rising edge SHALL set FSM=IDLE, RX_ACK=0, pointers=0, COUNT=0, MSG_CNT=0, OUT_VALID=0, EMPTY=1, FULL=0, STALL=0; entry storage need not be cleared.
REQ-028 Reset asserted mid-handshake (ACKED) SHALL drop RX_ACK the next edge and discard all buffered entries, including partial messages.

Structure
REQ-029 Default widths/depth and FSM state encodings SHALL live in the shared ulpb package/header alongside the node constants.
REQ-030 Storage SHALL be one sub-module, ulpb_sync_fifo (parameterised width ADDR_WIDTH+DATA_WIDTH+1, DEPTH); handshake FSM and MSG_CNT stay in ulpb_rx_buffer.

Verification
REQ-031 Single word: RX_ADDR=8'hcd, RX_DATA=32'h12345678, RX_PEND=0, OUT_READY=0 -> RX_ACK↑ 1 cycle after REQ; OUT_VALID=1, OUT_LAST=1, COUNT=1, MSG_CNT=1.
REQ-032 Stream of 8 words (PEND=1 ×7, then 0), OUT_READY=0, DEPTH=8 -> all acked, FULL=1, MSG_CNT=1; popping yields identical order, only 8th has OUT_LAST=1.
REQ-033 Overflow: 9th RX_REQ while FULL -> RX_ACK stays 0, STALL=1; one pop -> ACK↑ next cycle, STALL=0, COUNT back to 8.
REQ-034 Simultaneous write and pop at COUNT=3 -> COUNT stays 3, data order preserved across pointer wrap after 20 words.
REQ-035 RESET=0 while ACKED with COUNT=5 -> next edge RX_ACK=0, COUNT=0, EMPTY=1, OUT_VALID=0.
REQ-036 RX_REQ held high 10 cycles after ACK -> exactly one entry written, RX_ACK stays 1 until REQ↓.
